// File: rtl/kda_pkg.sv
// Shared types and constants for the KDA request packer.
// Optional overflow error handling is enabled by defining KDA_REQ_PACKER_ERR_EN.
package kda_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd1,
    ST_SALT = 2'd2,
    ST_SEND = 2'd3
  } kda_state_e;

  localparam int unsigned KDA_REQ_BEATS  = 17;
  localparam int unsigned KDA_PASS_BYTES = 64;
  localparam int unsigned KDA_SALT_MAX   = 63;

  localparam int unsigned KDA_BUF_W      = 512;
  localparam int unsigned KDA_CNT_W      = 7;
  localparam int unsigned KDA_BEAT_W     = 64;
  localparam int unsigned KDA_BEAT_CNT_W = 5;

  // Header beat field positions
  localparam int unsigned HDR_CHUNKS_LSB   = 38;
  localparam int unsigned HDR_SALT_LEN_LSB = 32;
  localparam int unsigned HDR_ITERS_LSB    = 0;

endpackage

// File: rtl/kda_req_packer_if.sv
// Config, byte-stream and KDA-side request signals of the packer.
// master = upstream/KDA environment side, slave = the packer itself.
interface kda_req_packer_if;
  logic [1:0]  cfg_chunks_i;
  logic [31:0] cfg_iters_i;
  logic        cfg_v_i;
  logic        cfg_ready_o;
  logic [7:0]  byte_i;
  logic        byte_last_i;
  logic        byte_v_i;
  logic        byte_ready_o;
  logic [63:0] data_o;
  logic        v_o;
  logic        ready_i;
  logic        err_o;

  modport master (
    output cfg_chunks_i, cfg_iters_i, cfg_v_i, byte_i, byte_last_i, byte_v_i, ready_i,
    input  cfg_ready_o, byte_ready_o, data_o, v_o, err_o
  );

  modport slave (
    input  cfg_chunks_i, cfg_iters_i, cfg_v_i, byte_i, byte_last_i, byte_v_i, ready_i,
    output cfg_ready_o, byte_ready_o, data_o, v_o, err_o
  );
endinterface

// File: rtl/kda_byte_accum.sv
// 512-bit byte-insert buffer: first byte lands in the MSB, count saturates at LIMIT,
// bytes beyond LIMIT are dropped and raise a sticky overflow flag.
module kda_byte_accum
  import kda_pkg::*;
#(
  parameter int unsigned LIMIT = 64
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  input  logic                 clr_i,
  input  logic                 wr_i,
  input  logic [7:0]           byte_i,
  output logic [KDA_BUF_W-1:0] fld_o,
  output logic [KDA_CNT_W-1:0] cnt_o,
  output logic                 ovf_o
);

  // Clear on new request, otherwise insert at byte slot 63-cnt or flag overflow
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      fld_o <= '0;
      cnt_o <= '0;
      ovf_o <= 1'b0;
    end else if (clr_i) begin
      fld_o <= '0;
      cnt_o <= '0;
      ovf_o <= 1'b0;
    end else if (wr_i) begin
      if (cnt_o < KDA_CNT_W'(LIMIT)) begin
        fld_o[{~6'(cnt_o), 3'd0} +: 8] <= byte_i;
        cnt_o <= cnt_o + KDA_CNT_W'(1);
      end else begin
        ovf_o <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/kda_req_packer.sv
// Packs config + password/salt byte stream into the 17-beat KDA request.
// Define KDA_REQ_PACKER_ERR_EN to drop overflowed requests and pulse err_o;
// otherwise overflow truncates silently and err_o stays 0.
module kda_req_packer
  import kda_pkg::*;
(
  input logic             clk_i,
  input logic             reset_ni,
  kda_req_packer_if.slave bus
);

`ifdef KDA_REQ_PACKER_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  kda_state_e                state_q, state_n;
  logic [KDA_BEAT_CNT_W-1:0] beat_q, beat_n;
  logic [1:0]                chunks_q;
  logic [31:0]               iters_q;
  logic [KDA_BEAT_W-1:0]     data_n, word_c;
  logic                      err_n;

  logic [KDA_BUF_W-1:0] pass_fld, salt_fld;
  logic [KDA_CNT_W-1:0] pass_cnt_unused, salt_cnt, salt_len_n;
  logic                 pass_ovf, salt_ovf, salt_at_lim, ovf_any;
  logic                 cfg_hs, byte_hs, beat_hs, pass_wr, salt_wr;

  assign cfg_hs      = bus.cfg_v_i & bus.cfg_ready_o;
  assign byte_hs     = bus.byte_v_i & bus.byte_ready_o;
  assign beat_hs     = bus.v_o & bus.ready_i;
  assign pass_wr     = byte_hs & (state_q == ST_PASS);
  assign salt_wr     = byte_hs & (state_q == ST_SALT);
  assign salt_at_lim = salt_cnt >= KDA_CNT_W'(KDA_SALT_MAX);
  assign salt_len_n  = salt_at_lim ? salt_cnt : salt_cnt + KDA_CNT_W'(1);
  assign ovf_any     = pass_ovf | salt_ovf | salt_at_lim;

  kda_byte_accum #(.LIMIT(KDA_PASS_BYTES)) u_pass (
    .clk_i   (clk_i),
    .reset_ni(reset_ni),
    .clr_i   (cfg_hs),
    .wr_i    (pass_wr),
    .byte_i  (bus.byte_i),
    .fld_o   (pass_fld),
    .cnt_o   (pass_cnt_unused),
    .ovf_o   (pass_ovf)
  );

  kda_byte_accum #(.LIMIT(KDA_SALT_MAX)) u_salt (
    .clk_i   (clk_i),
    .reset_ni(reset_ni),
    .clr_i   (cfg_hs),
    .wr_i    (salt_wr),
    .byte_i  (bus.byte_i),
    .fld_o   (salt_fld),
    .cnt_o   (salt_cnt),
    .ovf_o   (salt_ovf)
  );

  // Select the 64-bit field word for data beat beat_n (1..8 pass, 9..16 salt)
  always_comb begin
    word_c = '0;
    if (beat_n <= KDA_BEAT_CNT_W'(8)) begin
      word_c = pass_fld[{~3'(beat_n - KDA_BEAT_CNT_W'(1)), 6'd0} +: KDA_BEAT_W];
    end else begin
      word_c = salt_fld[{~3'(beat_n - KDA_BEAT_CNT_W'(9)), 6'd0} +: KDA_BEAT_W];
    end
  end

  // Next-state, beat counter and next output word
  always_comb begin
    state_n = state_q;
    beat_n  = beat_q;
    data_n  = bus.data_o;
    err_n   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cfg_hs) state_n = ST_PASS;
      end
      ST_PASS: begin
        if (byte_hs && bus.byte_last_i) state_n = ST_SALT;
      end
      ST_SALT: begin
        if (byte_hs && bus.byte_last_i) begin
          if (ERR_EN && ovf_any) begin
            state_n = ST_IDLE;
            err_n   = 1'b1;
          end else begin
            state_n = ST_SEND;
            beat_n  = '0;
            data_n  = (KDA_BEAT_W'(chunks_q) << HDR_CHUNKS_LSB)
                    | (KDA_BEAT_W'(6'(salt_len_n)) << HDR_SALT_LEN_LSB)
                    | (KDA_BEAT_W'(iters_q) << HDR_ITERS_LSB);
          end
        end
      end
      ST_SEND: begin
        if (beat_hs) begin
          if (beat_q == KDA_BEAT_CNT_W'(KDA_REQ_BEATS - 1)) begin
            state_n = ST_IDLE;
            beat_n  = '0;
            data_n  = '0;
          end else begin
            beat_n = beat_q + KDA_BEAT_CNT_W'(1);
            data_n = word_c;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State, config latch and registered outputs
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q          <= ST_IDLE;
      beat_q           <= '0;
      chunks_q         <= '0;
      iters_q          <= '0;
      bus.cfg_ready_o  <= 1'b1;
      bus.byte_ready_o <= 1'b0;
      bus.v_o          <= 1'b0;
      bus.data_o       <= '0;
      bus.err_o        <= 1'b0;
    end else begin
      state_q          <= state_n;
      beat_q           <= beat_n;
      if (cfg_hs) begin
        chunks_q <= bus.cfg_chunks_i;
        iters_q  <= bus.cfg_iters_i;
      end
      bus.cfg_ready_o  <= (state_n == ST_IDLE);
      bus.byte_ready_o <= (state_n == ST_PASS) || (state_n == ST_SALT);
      bus.v_o          <= (state_n == ST_SEND);
      bus.data_o       <= data_n;
      bus.err_o        <= err_n;
    end
  end

endmodule

// File: tb/tb_kda_req_packer.sv
// Scoreboard bench for kda_req_packer: the driver pushes expected beats,
// a negedge monitor pops and compares on every accepted beat.
module tb_kda_req_packer;

  logic clk_i = 1'b0;
  logic reset_ni;

  always #5 clk_i = ~clk_i;

  kda_req_packer_if bus();

  kda_req_packer dut (
    .clk_i   (clk_i),
    .reset_ni(reset_ni),
    .bus     (bus)
  );

  int          tests = 0;
  int          fails = 0;
  int          beats_seen = 0;
  int          err_cnt = 0;
  bit          bp_en = 1'b0;
  logic [63:0] exp_q[$];
  logic [7:0]  pass_q[$];
  logic [7:0]  salt_q[$];
  logic        stall_v = 1'b0;
  logic [63:0] stall_d = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare accepted beats, check data held across stalls, count err pulses
  always @(negedge clk_i) begin
    if (!reset_ni) begin
      stall_v = 1'b0;
    end else begin
      if (bus.v_o) begin
        if (stall_v) chk("stall_hold", bus.data_o, stall_d);
        if (bus.ready_i) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", 64'(bus.v_o), 64'd0);
          end else begin
            chk($sformatf("beat%0d", beats_seen), bus.data_o, exp_q.pop_front());
            beats_seen++;
          end
          stall_v = 1'b0;
        end else begin
          stall_v = 1'b1;
          stall_d = bus.data_o;
        end
      end else begin
        stall_v = 1'b0;
      end
      if (bus.err_o) err_cnt++;
    end
  end

  // KDA-side ready: held high, or pseudo-random while backpressure is enabled
  initial begin
    bus.ready_i = 1'b1;
    forever begin
      @(posedge clk_i);
      #1;
      bus.ready_i = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  function automatic void load_pass(input string s);
    pass_q.delete();
    for (int i = 0; i < s.len(); i++) pass_q.push_back(8'(s[i]));
  endfunction

  function automatic void load_salt(input string s);
    salt_q.delete();
    for (int i = 0; i < s.len(); i++) salt_q.push_back(8'(s[i]));
  endfunction

  // Hand-computed beats for chunks=2, iters=0x1000, "password"/"salt"
  function automatic void push_basic();
    exp_q.push_back(64'h0000_0084_0000_1000);
    exp_q.push_back(64'h7061_7373_776F_7264);
    repeat (7) exp_q.push_back(64'h0);
    exp_q.push_back(64'h7361_6C74_0000_0000);
    repeat (7) exp_q.push_back(64'h0);
  endfunction

  // Reference packing with truncation to 64 pass / 63 salt bytes
  function automatic void push_model(input logic [1:0] ch, input logic [31:0] it);
    logic [511:0] p;
    logic [511:0] s;
    int sl;
    p = '0;
    s = '0;
    sl = 0;
    for (int i = 0; i < pass_q.size() && i < 64; i++) p[511-8*i -: 8] = pass_q[i];
    for (int i = 0; i < salt_q.size() && i < 63; i++) begin
      s[511-8*i -: 8] = salt_q[i];
      sl++;
    end
    exp_q.push_back({24'h0, ch, 6'(sl), it});
    for (int k = 0; k < 8; k++) exp_q.push_back(p[511-64*k -: 64]);
    for (int k = 0; k < 8; k++) exp_q.push_back(s[511-64*k -: 64]);
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic last);
    int t;
    t = 0;
    bus.byte_i      = b;
    bus.byte_last_i = last;
    bus.byte_v_i    = 1'b1;
    while (!bus.byte_ready_o && t < 50) begin
      @(posedge clk_i);
      #1;
      t++;
    end
    chk("byte_ready", 64'(bus.byte_ready_o), 64'd1);
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_req(input logic [1:0] ch, input logic [31:0] it);
    int t;
    t = 0;
    while (!bus.cfg_ready_o && t < 200) begin
      @(posedge clk_i);
      #1;
      t++;
    end
    chk("cfg_ready", 64'(bus.cfg_ready_o), 64'd1);
    bus.cfg_chunks_i = ch;
    bus.cfg_iters_i  = it;
    bus.cfg_v_i      = 1'b1;
    @(posedge clk_i);
    #1;
    bus.cfg_v_i = 1'b0;
    for (int i = 0; i < pass_q.size(); i++) send_byte(pass_q[i], i == pass_q.size() - 1);
    for (int i = 0; i < salt_q.size(); i++) send_byte(salt_q[i], i == salt_q.size() - 1);
    bus.byte_v_i    = 1'b0;
    bus.byte_last_i = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!bus.cfg_ready_o && n < 400) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    chk("done", 64'(bus.cfg_ready_o), 64'd1);
  endtask

  initial begin
    int n;
    int e0;
    int base;
    reset_ni         = 1'b0;
    bus.cfg_chunks_i = '0;
    bus.cfg_iters_i  = '0;
    bus.cfg_v_i      = 1'b0;
    bus.byte_i       = '0;
    bus.byte_last_i  = 1'b0;
    bus.byte_v_i     = 1'b0;

    // Reset state
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_cfg_ready", 64'(bus.cfg_ready_o), 64'd1);
    chk("rst_byte_ready", 64'(bus.byte_ready_o), 64'd0);
    chk("rst_v", 64'(bus.v_o), 64'd0);
    chk("rst_data", bus.data_o, 64'd0);
    chk("rst_err", 64'(bus.err_o), 64'd0);
    #2 reset_ni = 1'b1;

    // Basic request, ready held high
    load_pass("password");
    load_salt("salt");
    push_basic();
    drive_req(2'd2, 32'h1000);
    chk("v_rise", 64'(bus.v_o), 64'd1);
    wait_done(n);
    chk("beat_cycles", 64'(n), 64'd17);
    chk("drain_basic", 64'(exp_q.size()), 64'd0);

    // Same request under random backpressure
    bp_en = 1'b1;
    push_basic();
    drive_req(2'd2, 32'h1000);
    wait_done(n);
    bp_en = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("drain_bp", 64'(exp_q.size()), 64'd0);

    // Full-length fields: 64-byte pass, 63-byte salt
    pass_q.delete();
    salt_q.delete();
    for (int i = 0; i < 64; i++) pass_q.push_back(8'(i * 3 + 1));
    for (int i = 0; i < 63; i++) salt_q.push_back(8'(8'h80 + i));
    push_model(2'd3, 32'hDEAD_BEEF);
    e0 = err_cnt;
    drive_req(2'd3, 32'hDEAD_BEEF);
    chk("v_rise_full", 64'(bus.v_o), 64'd1);
    wait_done(n);
    repeat (2) @(posedge clk_i);
    #1;
    chk("drain_full", 64'(exp_q.size()), 64'd0);
    chk("err_full", 64'(err_cnt - e0), 64'd0);

    // Overflow: 70-byte pass
    pass_q.delete();
    for (int i = 0; i < 70; i++) pass_q.push_back(8'(i + 1));
    load_salt("ab");
    e0 = err_cnt;
`ifdef KDA_REQ_PACKER_ERR_EN
    drive_req(2'd1, 32'd5);
    chk("v_ovf", 64'(bus.v_o), 64'd0);
    wait_done(n);
    repeat (3) @(posedge clk_i);
    #1;
    chk("err_ovf", 64'(err_cnt - e0), 64'd1);
    chk("v_ovf_after", 64'(bus.v_o), 64'd0);
`else
    push_model(2'd1, 32'd5);
    drive_req(2'd1, 32'd5);
    chk("v_rise_ovf", 64'(bus.v_o), 64'd1);
    wait_done(n);
    repeat (2) @(posedge clk_i);
    #1;
    chk("drain_ovf", 64'(exp_q.size()), 64'd0);
    chk("err_ovf", 64'(err_cnt - e0), 64'd0);
`endif

    // Reset mid-SEND, then a short request must show no residue
    pass_q.delete();
    salt_q.delete();
    for (int i = 0; i < 40; i++) pass_q.push_back(8'(8'hA0 + i));
    for (int i = 0; i < 30; i++) salt_q.push_back(8'(8'h30 + i));
    push_model(2'd0, 32'd7);
    base = beats_seen;
    drive_req(2'd0, 32'd7);
    n = 0;
    while ((beats_seen - base) < 5 && n < 100) begin
      @(posedge clk_i);
      #2;
      n++;
    end
    chk("reach_beat5", 64'(beats_seen - base), 64'd5);
    reset_ni = 1'b0;
    #1;
    chk("arst_v", 64'(bus.v_o), 64'd0);
    chk("arst_cfg_ready", 64'(bus.cfg_ready_o), 64'd1);
    chk("arst_data", bus.data_o, 64'd0);
    exp_q.delete();
    @(posedge clk_i);
    #3 reset_ni = 1'b1;

    load_pass("ab");
    load_salt("c");
    push_model(2'd1, 32'd9);
    drive_req(2'd1, 32'd9);
    chk("v_rise_post", 64'(bus.v_o), 64'd1);
    wait_done(n);
    repeat (2) @(posedge clk_i);
    #1;
    chk("drain_post", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
